demux_rr_sched: RTL



---
 rtl/demux_rr_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler and bit router for a 16-way 1-bit demux datapath.
// Optional feature: define DEMUX_SCHED_PRIO0_EN to give channel 0 absolute priority at arbitration.
module demux_rr_sched #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic [15:0] y,
  output logic [15:0] y_valid
);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t            state, state_nxt;
  logic [3:0]        sel_nxt;
  logic [3:0]        last_ptr, last_ptr_nxt;
  logic [15:0]       gnt_nxt;
  logic              busy_nxt;
  logic [15:0]       y_nxt, y_valid_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

  logic [3:0]        rr_winner;
  logic [3:0]        winner;
  logic              rr_found;
  logic              accept;
  logic              abort;
  logic              burst_end;

  // Search upward from the channel after the last owner; offset 16 wraps back to last_ptr itself.
  always_comb begin
    rr_winner = last_ptr;
    rr_found  = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (!rr_found && req[last_ptr + 4'(k)]) begin
        rr_winner = last_ptr + 4'(k);
        rr_found  = 1'b1;
      end
    end
  end

`ifdef DEMUX_SCHED_PRIO0_EN
  assign winner = req[0] ? 4'd0 : rr_winner;
`else
  assign winner = rr_winner;
`endif

  assign din_ready = (state == XFER) && req[sel];
  assign accept    = din_ready && din_valid;
  assign abort     = (state == XFER) && !req[sel];
  assign burst_end = accept && (beat_cnt == LAST_BEAT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt    = state;
    sel_nxt      = sel;
    last_ptr_nxt = last_ptr;
    gnt_nxt      = gnt;
    busy_nxt     = busy;
    beat_cnt_nxt = beat_cnt;
    y_nxt        = '0;
    y_valid_nxt  = '0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = XFER;
          sel_nxt      = winner;
          gnt_nxt      = 16'(1) << winner;
          busy_nxt     = 1'b1;
          beat_cnt_nxt = '0;
        end
      end

      XFER: begin
        if (abort) begin
          state_nxt    = IDLE;
          last_ptr_nxt = sel;
          gnt_nxt      = '0;
          busy_nxt     = 1'b0;
          beat_cnt_nxt = '0;
        end else if (accept) begin
          y_nxt[sel]       = din;
          y_valid_nxt[sel] = 1'b1;
          if (burst_end) begin
            state_nxt    = IDLE;
            last_ptr_nxt = sel;
            gnt_nxt      = '0;
            busy_nxt     = 1'b0;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel      <= '0;
      last_ptr <= 4'd15;
      gnt      <= '0;
      busy     <= 1'b0;
      beat_cnt <= '0;
      y        <= '0;
      y_valid  <= '0;
    end else begin
      sel      <= sel_nxt;
      last_ptr <= last_ptr_nxt;
      gnt      <= gnt_nxt;
      busy     <= busy_nxt;
      beat_cnt <= beat_cnt_nxt;
      y        <= y_nxt;
      y_valid  <= y_valid_nxt;
    end
  end

  // Structural invariants of the outputs.
  ap_yv_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y_valid));
  ap_y_in_yv   : assert property (@(posedge clk) disable iff (!rst_n) (y & ~y_valid) == '0);
  ap_gnt_oh    : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  ap_busy_gnt  : assert property (@(posedge clk) disable iff (!rst_n) busy == (|gnt));

endmodule
